// File: rtl/me_pkg.sv
// Shared row geometry and loader FSM encoding for the motion-estimation datapath.
package me_pkg;
   localparam int PIXEL = 8;
   localparam int X     = 32;
   localparam int ROW_W = PIXEL * X;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } load_state_t;
endpackage

// File: rtl/row_fifo2.sv
// Two-entry row FIFO; head is visible combinationally, push on full is accepted only with a pop.
// Latency: a pushed row is at the head the cycle after the push when the FIFO was empty.
module row_fifo2 #(
   parameter int W = me_pkg::ROW_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         do_push;
   logic         do_pop;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign do_pop  = pop & ~empty;
   assign do_push = push & (~full | do_pop);
   assign dout    = mem[rd_ptr];

   // On full, wr_ptr == rd_ptr: the head slot is overwritten as it is read out.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mem[0] <= '0;
         mem[1] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + {1'b0, do_push} - {1'b0, do_pop};
      end
   end
endmodule

// File: rtl/ref_row_loader.sv
// Loads ROWS search-window rows from external memory into the reference memory, one request in flight.
// Latency: mem_ack at t gives beg_en at t+1; dst_ready low fills the 2-row FIFO, then mem_req is withheld.
module ref_row_loader #(
   parameter int PIXEL = me_pkg::PIXEL,
   parameter int X     = me_pkg::X,
   parameter int ROWS  = 64
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   input  logic [19:0]          base_addr,
   input  logic [19:0]          stride,
   output logic                 mem_req,
   output logic [19:0]          mem_addr,
   input  logic                 mem_ack,
   input  logic [PIXEL*X-1:0]   mem_data,
   output logic [PIXEL*X-1:0]   ref_input,
   output logic                 beg_en,
   output logic [6:0]           wr_address,
   input  logic                 dst_ready,
   output logic                 busy,
   output logic                 done
);
   import me_pkg::*;

   localparam logic [7:0] ROWS_N = 8'(ROWS);

   load_state_t state;
   logic [7:0]  req_cnt;
   logic [7:0]  wr_cnt;
   logic [19:0] stride_q;
   logic        fifo_full;
   logic        fifo_empty;
   logic        push;

   // An ack without a pending request (stray or post-reset) never reaches the FIFO.
   assign push       = mem_req & mem_ack;
   assign beg_en     = ~fifo_empty & dst_ready;
   assign wr_address = wr_cnt[6:0];

   row_fifo2 #(.W(PIXEL*X)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (mem_data),
      .pop   (beg_en),
      .dout  (ref_input),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   // mem_addr doubles as the running row address so it is stable while mem_req is high.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         stride_q <= '0;
         req_cnt  <= '0;
         wr_cnt   <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         if (push) begin
            mem_req  <= 1'b0;
            mem_addr <= mem_addr + stride_q;
            req_cnt  <= req_cnt + 8'd1;
         end
         if (beg_en) wr_cnt <= wr_cnt + 8'd1;

         case (state)
            IDLE: begin
               if (start) begin
                  state    <= FETCH;
                  busy     <= 1'b1;
                  mem_addr <= base_addr;
                  stride_q <= stride;
                  req_cnt  <= '0;
                  wr_cnt   <= '0;
               end
            end
            FETCH: begin
               if (req_cnt == ROWS_N) state <= FLUSH;
               else if (!mem_req && !fifo_full) mem_req <= 1'b1;
            end
            FLUSH: begin
               if (wr_cnt == ROWS_N) begin
                  state <= DONE;
                  done  <= 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule
